// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM generator with shared edge/center-aligned counter, prescaler
// and a double-buffered duty frame that commits only on a period boundary.
module pwm_multi_ch #(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned STAGE   = 8,
  parameter int unsigned PSWIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               data_valid,
  input  logic [DWIDTH-1:0]  data,
  output logic               data_ready,
  input  logic               center_mode,
  input  logic [STAGE-1:0]   invert,
  input  logic [PSWIDTH-1:0] prescale,
  output logic               period_start,
  output logic               frame_done,
  output logic [STAGE-1:0]   out
);

  localparam int unsigned IW = (STAGE > 1) ? $clog2(STAGE) : 1;
  localparam logic [DWIDTH-1:0] CNT_MAX  = {DWIDTH{1'b1}};
  localparam logic [IW-1:0]     LAST_IDX = IW'(STAGE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t             state;
  logic [IW-1:0]      idx;
  logic [DWIDTH-1:0]  shadow [STAGE];
  logic [DWIDTH-1:0]  active [STAGE];

  logic [PSWIDTH-1:0] ps_cnt;
  logic [PSWIDTH-1:0] ps_lat;
  logic               mode_lat;
  logic [DWIDTH-1:0]  cnt;
  logic               cnt_down;

  logic [DWIDTH-1:0]  cnt_nxt_c;
  logic               down_nxt_c;
  logic               tick_c;
  logic               boundary_c;

  // Next counter value for the period shape latched at the last boundary
  always_comb begin
    tick_c     = (ps_cnt == ps_lat);
    cnt_nxt_c  = cnt + DWIDTH'(1);
    down_nxt_c = cnt_down;
    if (mode_lat) begin
      if (cnt_down) begin
        cnt_nxt_c = cnt - DWIDTH'(1);
      end else if (cnt == CNT_MAX) begin
        cnt_nxt_c  = CNT_MAX - DWIDTH'(1);
        down_nxt_c = 1'b1;
      end
    end
    boundary_c = tick_c && (cnt_nxt_c == '0);
  end

  // Prescaler, period counter and per-period configuration snapshot
  always_ff @(posedge clk) begin
    if (!rst) begin
      ps_cnt       <= '0;
      ps_lat       <= prescale;
      mode_lat     <= center_mode;
      cnt          <= '0;
      cnt_down     <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary_c;
      if (tick_c) begin
        ps_cnt   <= '0;
        cnt      <= cnt_nxt_c;
        cnt_down <= boundary_c ? 1'b0 : down_nxt_c;
      end else begin
        ps_cnt <= ps_cnt + PSWIDTH'(1);
      end
      if (boundary_c) begin
        ps_lat   <= prescale;
        mode_lat <= center_mode;
      end
    end
  end

  // Duty frame loader: shadow fills word by word, active swaps at a boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= '0;
      data_ready <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < int'(STAGE); i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            idx        <= '0;
            data_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (data_valid) begin
            shadow[idx] <= data;
            idx         <= idx + IW'(1);
            if (idx == LAST_IDX) begin
              state      <= PEND;
              data_ready <= 1'b0;
            end
          end
        end
        PEND: begin
          if (boundary_c) begin
            for (int i = 0; i < int'(STAGE); i++) begin
              active[i] <= shadow[i];
            end
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          data_ready <= 1'b0;
        end
      endcase
    end
  end

  // Compare stage; active and cnt change on the same edge, so out never glitches
  always_ff @(posedge clk) begin
    if (!rst) begin
      out <= '0;
    end else begin
      for (int i = 0; i < int'(STAGE); i++) begin
        out[i] <= (active[i] > cnt) ^ invert[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Scoreboard bench for pwm_multi_ch: stimulus queues expected per-period
// high counts, a monitor measures each period window and compares.
module tb_pwm_multi_ch;

  localparam int unsigned DW  = 8;
  localparam int unsigned NS  = 4;
  localparam int unsigned PSW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           data_valid;
  logic [DW-1:0]  data;
  logic           data_ready;
  logic           center_mode;
  logic [NS-1:0]  invert;
  logic [PSW-1:0] prescale;
  logic           period_start;
  logic           frame_done;
  logic [NS-1:0]  out;

  typedef struct packed {
    logic [15:0]          period;
    logic [NS-1:0][15:0]  high;
  } rec_t;

  rec_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   fd_count = 0;

  pwm_multi_ch #(.DWIDTH(DW), .STAGE(NS), .PSWIDTH(PSW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .data_valid   (data_valid),
    .data         (data),
    .data_ready   (data_ready),
    .center_mode  (center_mode),
    .invert       (invert),
    .prescale     (prescale),
    .period_start (period_start),
    .frame_done   (frame_done),
    .out          (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic rec_t mk(input int p, input int h0, input int h1, input int h2, input int h3);
    rec_t r;
    r.period  = 16'(p);
    r.high[0] = 16'(h0);
    r.high[1] = 16'(h1);
    r.high[2] = 16'(h2);
    r.high[3] = 16'(h3);
    return r;
  endfunction

  // Monitor: a window spans the cycles whose out reflects counter 0..end of one period
  initial begin : monitor
    int   acc [NS];
    int   len;
    bit   armed;
    bit   ps_d;
    rec_t e;
    armed = 1'b0;
    ps_d  = 1'b0;
    len   = 0;
    for (int i = 0; i < int'(NS); i++) acc[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      if (frame_done === 1'b1) fd_count++;
      if (rst !== 1'b1) begin
        armed = 1'b0;
        ps_d  = 1'b0;
      end else begin
        if (ps_d) begin
          if (armed) begin
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL scoreboard_underflow: got empty queue expected a record");
            end else begin
              e = exp_q.pop_front();
              check("period_len", 32'(len), 32'(e.period));
              for (int i = 0; i < int'(NS); i++)
                check($sformatf("high_ch%0d", i), 32'(acc[i]), 32'(e.high[i]));
            end
          end
          armed = (exp_q.size() > 0);
          len   = 0;
          for (int i = 0; i < int'(NS); i++) acc[i] = 0;
        end
        len++;
        for (int i = 0; i < int'(NS); i++) acc[i] += int'(out[i]);
        ps_d = (period_start === 1'b1);
      end
    end
  end

  task automatic wait_fd(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < budget);
    if (frame_done !== 1'b1) check("frame_done_timeout", 32'(frame_done), 32'(1));
  endtask

  task automatic wait_ps(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < budget);
    if (period_start !== 1'b1) check("period_start_timeout", 32'(period_start), 32'(1));
  endtask

  task automatic wait_empty(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("scoreboard_drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
  endtask

  task automatic load_frame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3);
    logic [NS-1:0][7:0] w;
    w = {d3, d2, d1, d0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_in_load", 32'(data_ready), 32'(1));
    for (int i = 0; i < int'(NS); i++) begin
      data       = w[i];
      data_valid = 1'b1;
      @(negedge clk);
    end
    data_valid = 1'b0;
    check("ready_after_load", 32'(data_ready), 32'(0));
  endtask

  initial begin : stim
    int n;
    int fd_before;
    rst = 1'b0; start = 1'b0; data_valid = 1'b0; data = '0;
    center_mode = 1'b0; invert = '0; prescale = '0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out), 32'(0));
    check("rst_ready", 32'(data_ready), 32'(0));
    check("rst_period_start", 32'(period_start), 32'(0));
    check("rst_frame_done", 32'(frame_done), 32'(0));
    rst = 1'b1;

    // Edge mode, prescale 0
    load_frame(8'd0, 8'd64, 8'd128, 8'd255);
    wait_fd(600);
    check("fd_with_period_start", 32'(period_start), 32'(1));
    exp_q.push_back(mk(256, 0, 64, 128, 255));
    exp_q.push_back(mk(256, 0, 64, 128, 255));
    wait_empty(1000);
    check("fd_count_edge", 32'(fd_count), 32'(1));

    // Center mode
    center_mode = 1'b1;
    load_frame(8'd100, 8'd0, 8'd255, 8'd1);
    wait_fd(1200);
    exp_q.push_back(mk(510, 199, 0, 509, 1));
    exp_q.push_back(mk(510, 199, 0, 509, 1));
    wait_empty(1500);

    // Edge mode, prescale 3
    center_mode = 1'b0;
    prescale    = 4'd3;
    load_frame(8'd128, 8'd0, 8'd255, 8'd64);
    wait_fd(3000);
    exp_q.push_back(mk(1024, 512, 0, 1020, 256));
    exp_q.push_back(mk(1024, 512, 0, 1020, 256));
    wait_empty(2500);
    check("fd_count_prescale", 32'(fd_count), 32'(3));

    // Zero duties with inversion
    prescale = 4'd0;
    load_frame(8'd0, 8'd0, 8'd0, 8'd0);
    wait_fd(3000);
    invert = 4'b0101;
    exp_q.push_back(mk(256, 256, 0, 256, 0));
    repeat (5) @(negedge clk);
    check("invert_out", 32'(out), 32'(4'b0101));
    wait_empty(600);

    // Mid-period load with ignored data_valid/start while not ready
    wait_ps(600, n);
    invert = 4'b0000;
    exp_q.push_back(mk(256, 0, 0, 0, 0));
    repeat (40) @(negedge clk);
    data = 8'd200; data_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ready_idle", 32'(data_ready), 32'(0));
    end
    data_valid = 1'b0;
    load_frame(8'd10, 8'd20, 8'd30, 8'd40);
    data = 8'd7; data_valid = 1'b1; start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("ready_pend", 32'(data_ready), 32'(0));
    end
    data_valid = 1'b0; start = 1'b0;
    wait_fd(600);
    check("fd_with_period_start_mid", 32'(period_start), 32'(1));
    exp_q.push_back(mk(256, 10, 20, 30, 40));
    wait_empty(600);
    check("fd_count_mid", 32'(fd_count), 32'(5));

    // Reset in the middle of a load
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; data = 8'd5; data_valid = 1'b1;
    @(negedge clk);
    data = 8'd6;
    @(negedge clk);
    data_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_out", 32'(out), 32'(0));
    check("midrst_ready", 32'(data_ready), 32'(0));
    check("midrst_period_start", 32'(period_start), 32'(0));
    check("midrst_frame_done", 32'(frame_done), 32'(0));
    fd_before = fd_count;
    rst = 1'b1;
    wait_ps(600, n);
    check("first_period_after_rst", 32'(n), 32'(256));
    exp_q.push_back(mk(256, 0, 0, 0, 0));
    wait_empty(600);
    check("no_fd_after_rst", 32'(fd_count), 32'(fd_before));
    check("ready_after_rst", 32'(data_ready), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pwm_multi_ch.md
PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
REQ-001 Parameter DWIDTH, default 8, duty/counter width in bits.
REQ-002 Parameter STAGE, default 8, number of PWM channels.
REQ-003 Parameter PSWIDTH, default 4, prescaler control width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin loading a new duty frame.
REQ-007 data_valid  input  1  duty word on data is valid.
REQ-008 data  input  DWIDTH  duty word, unsigned; channel 0 first, channel STAGE-1 last.
REQ-009 data_ready  output  1  block accepts a duty word this cycle.
REQ-010 center_mode  input  1  0 = edge-aligned, 1 = center-aligned counting.
REQ-011 invert  input  STAGE  per-channel output polarity inversion.
REQ-012 prescale  input  PSWIDTH  counter advances once every prescale+1 clocks.
REQ-013 period_start  output  1  one-cycle pulse when the counter restarts a period.
REQ-014 frame_done  output  1  one-cycle pulse when a loaded frame becomes active.
REQ-015 out  output  STAGE  registered PWM outputs.

Function
REQ-016 The prescaler SHALL count 0..prescale and assert an internal tick on the cycle it equals prescale, then return to 0; prescale=0 SHALL tick every clock.
REQ-017 Edge mode: on each tick the counter SHALL step 0,1,...,2^DWIDTH-1, then wrap to 0 (period 2^DWIDTH ticks).
REQ-018 Center mode: on each tick the counter SHALL step up 0..2^DWIDTH-1, then down 2^DWIDTH-2..1, then 0 (period 2*(2^DWIDTH-1) ticks).
REQ-019 Period boundary = a tick on which the counter becomes 0; period_start SHALL pulse on the cycle after that tick (aligned with counter==0 registered).
REQ-020 prescale and center_mode SHALL be sampled only at a period boundary; changes mid-period take effect from the next period.
REQ-021 out[i] SHALL equal (active[i] > counter) XOR invert[i], registered, one clock after the counter value it reflects.
REQ-022 Duty 0 SHALL give a constant low (non-inverted); duty 2^DWIDTH-1 SHALL be high for all counter values except 2^DWIDTH-1.
REQ-023 Load FSM states: IDLE, LOAD, PEND.
REQ-024 IDLE: data_ready=0; start=1 -> LOAD, word index cleared to 0.
REQ-025 LOAD: data_ready=1; each cycle with data_valid=1 SHALL write data to shadow[index] and increment index; on acceptance of word STAGE-1 -> PEND.
REQ-026 start asserted in LOAD or PEND SHALL be ignored; data_valid in IDLE or PEND SHALL be ignored (no write).
REQ-027 PEND: data_ready=0; at the next period boundary all active[i] SHALL load shadow[i] simultaneously, frame_done SHALL pulse one cycle, FSM -> IDLE.
REQ-028 If the last word is accepted on the same cycle as a boundary tick, commit SHALL occur at the following boundary, never mid-period.
REQ-029 Active duties SHALL never change except at a period boundary (no glitch on out).
REQ-030 Counter and duty comparisons SHALL be unsigned, width DWIDTH, no overflow beyond the stated wrap.

Reset
REQ-031 While rst=0 at a clock edge: counter, prescaler, index, shadow, active SHALL clear to 0; FSM -> IDLE; out, data_ready, period_start, frame_done SHALL be 0.
REQ-032 Reset mid-LOAD or mid-PEND SHALL discard the partial frame; no frame_done after release.
REQ-033 First tick after rst release SHALL occur prescale+1 clocks later with counter stepping from 0.

Verification
REQ-034 DWIDTH=8, STAGE=4, prescale=0, edge mode, load duties {0,64,128,255} -> after commit, per 256-cycle period out[0..3] high for 0,64,128,255 cycles; frame_done one pulse at boundary.
REQ-035 Center mode, duty 100, prescale=0 -> out[0] high 199 of 510 cycles per period, symmetric about counter==255.
REQ-036 prescale=3, duty 128 edge mode -> period 1024 clocks, out high 512 clocks; period_start every 1024 clocks.
REQ-037 Load finishes mid-period -> active duties unchanged until next period_start; data_valid pulses while data_ready=0 do not alter shadow.
REQ-038 invert=4'b0101 with duties {0,0,0,0} -> out = 4'b0101 constant after first registered cycle.
REQ-039 rst=0 asserted during LOAD after 2 of 4 words -> all outputs 0, previous active duties cleared, no frame_done after release.
